hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard controller for the 5-stage MIPS core. Generates the execute-stage operand forwarding selects (`forward_one_execute`, `forward_two_execute`) consumed by the ALU operand mux. Generates the fetch/decode stall and execute flush. Sequences the multi-cycle MULT/DIV unit through a busy state machine, and stalls HI/LO accesses while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 4: busy cycles after a MULT/MULTU start.
- `DIV_CYCLES`, default 32: busy cycles after a DIV/DIVU start.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rs_decode`, `rt_decode` in 5: source registers in decode.
- `rs_execute`, `rt_execute` in 5: source registers in execute.
- `branch_decode` in 1: branch/JR in decode (operands compared in decode).
- `hi_lo_access_decode` in 1: decode instruction is MFHI/MFLO/MTHI/MTLO/MULT/DIV.
- `write_reg_execute` in 5, `reg_write_execute` in 1, `mem_to_reg_execute` in 1: execute destination.
- `write_reg_memory` in 5, `reg_write_memory` in 1, `mem_to_reg_memory` in 1: memory destination.
- `write_reg_writeback` in 5, `reg_write_writeback` in 1: writeback destination.
- `use_lo_execute`, `use_hi_execute` in 1: execute instruction reads LO (operand A) / HI (operand B).
- `hi_lo_write_execute`, `hi_lo_write_memory`, `hi_lo_write_writeback` in 1: HI/LO written by that stage.
- `multdiv_start_execute` in 1: MULT/DIV in execute, one-cycle pulse.
- `multdiv_is_div_execute` in 1: qualifies the start; 1 = divide.
- `forward_one_execute` out 3, `forward_two_execute` out 3: operand selects.
- `stall_fetch`, `stall_decode`, `flush_execute` out 1.
- `multdiv_busy` out 1: FSM not IDLE.

## Operation
- Forward A, priority high to low:
  - `use_lo_execute` && `hi_lo_write_memory` → 100.
  - `use_lo_execute` && `hi_lo_write_writeback` → 011.
  - `rs_execute`≠0 && `reg_write_memory` && `rs_execute`==`write_reg_memory` → 010.
  - Same test against the writeback stage → 001.
  - Otherwise 000.
- Forward B: same rules with `rt_execute` and `use_hi_execute`; the HI codes are also 100/011.
- Register 0 is never forwarded.
- Load-use stall: `mem_to_reg_execute` && `reg_write_execute` && `write_reg_execute`≠0 && it equals `rs_decode` or `rt_decode`.
- Branch stall, only when `branch_decode` is high:
  - `reg_write_execute` with `write_reg_execute`≠0 matching `rs_decode`/`rt_decode`; or
  - `mem_to_reg_memory` with `write_reg_memory`≠0 matching `rs_decode`/`rt_decode`.
- HI/LO busy stall: `hi_lo_access_decode` && (`multdiv_busy` || `multdiv_start_execute`).
- Any stall drives `stall_fetch` = `stall_decode` = `flush_execute` = 1.
- FSM states: IDLE, MULT_BUSY, DIV_BUSY; down-counter `cnt` of width clog2(`DIV_CYCLES`)+1.
  - IDLE + start: go to DIV_BUSY or MULT_BUSY; `cnt` = `DIV_CYCLES`−1 or `MULT_CYCLES`−1.
  - BUSY: `cnt` decrements each cycle. With `cnt`==0, the next state is IDLE.
  - Start while BUSY (only if a stall was bypassed): restart with the new op and count; no error is raised.
- Reset values: state IDLE, `cnt` 0, `multdiv_busy` 0.
- When `reset` is high, the combinational outputs come from the inputs. The bench must drive quiescent inputs (all 0), which gives selects 000 and stalls 0.
- Reset asserted mid-operation aborts the operation and returns to IDLE on the next edge.

## Timing
- Forward selects and stalls are combinational from the same-cycle inputs; there is no latency.
- `multdiv_busy` rises on the edge after the start cycle. It stays high exactly `MULT_CYCLES`/`DIV_CYCLES` cycles.
- A HI/LO access in decode during the start cycle or the busy cycles is held.
- The held access enters execute on the cycle after `multdiv_busy` falls.
- Stall and flush assert together in the same cycle. The execute bubble has `reg_write_execute`=0.

## Configuration
- `HAZARD_FORWARD_HILO_EN` defined: HI/LO forwarding codes 011 and 100 are generated as above.
- Macro undefined:
  - `use_lo_execute`/`use_hi_execute` never produce 011/100.
  - An extra stall is added: `hi_lo_access_decode` && (`hi_lo_write_execute` || `hi_lo_write_memory` || `hi_lo_write_writeback`).
  - The HI/LO read then waits until the write commits.

## Test plan
- Forwarding priority:
  - `rs_execute`=5, memory writes r5, writeback writes r5 → `forward_one_execute`=010.
  - Memory `reg_write` deasserted → 001.
  - `rs_execute`=0 → 000.
- Load-use: `mem_to_reg_execute`=1, `write_reg_execute`=8, `rt_decode`=8 → stall/flush=1 for one cycle. The next cycle, with bubble inputs, → 0 and forward B=001 as the load reaches writeback.
- Branch: `branch_decode`=1, `reg_write_execute`=1, `write_reg_execute`=3, `rs_decode`=3 → stall=1. Same with `write_reg_execute`=0 → stall=0.
- DIV: start with is_div=1 at cycle T → `multdiv_busy` high for T+1..T+32. MFLO in decode stalls T..T+32 and releases at T+33.
- MULT then reset: start at T, `reset` at T+2 → busy=0 at T+3 and the stall is released.
- HI/LO forwarding: `use_hi_execute`=1, `hi_lo_write_memory`=1 → `forward_two_execute`=100 with the macro. Without the macro, the prior decode cycle stalled and no 100 code appears.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: execute-stage operand
// forwarding selects, fetch/decode stall with execute flush, and the busy
// sequencer for the multi-cycle MULT/DIV unit.
// Optional feature macro: HAZARD_FORWARD_HILO_EN enables HI/LO result
// forwarding (codes 011/100); without it a HI/LO read in decode is held
// until every in-flight HI/LO write has committed.
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_decode,
  input  logic [4:0] rt_decode,
  input  logic [4:0] rs_execute,
  input  logic [4:0] rt_execute,
  input  logic       branch_decode,
  input  logic       hi_lo_access_decode,
  input  logic [4:0] write_reg_execute,
  input  logic       reg_write_execute,
  input  logic       mem_to_reg_execute,
  input  logic [4:0] write_reg_memory,
  input  logic       reg_write_memory,
  input  logic       mem_to_reg_memory,
  input  logic [4:0] write_reg_writeback,
  input  logic       reg_write_writeback,
  input  logic       use_lo_execute,
  input  logic       use_hi_execute,
  input  logic       hi_lo_write_execute,
  input  logic       hi_lo_write_memory,
  input  logic       hi_lo_write_writeback,
  input  logic       multdiv_start_execute,
  input  logic       multdiv_is_div_execute,
  output logic [2:0] forward_one_execute,
  output logic [2:0] forward_two_execute,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_execute,
  output logic       multdiv_busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

`ifdef HAZARD_FORWARD_HILO_EN
  localparam bit HILO_FWD = 1'b1;
`else
  localparam bit HILO_FWD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_BUSY = 2'd1,
    DIV_BUSY  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               load_use_stall;
  logic               branch_stall;
  logic               hilo_busy_stall;
  logic               hilo_write_stall;
  logic               dec_rs_hit_ex, dec_rt_hit_ex;
  logic               dec_rs_hit_mem, dec_rt_hit_mem;

  // Multiply/divide sequencer state register; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: a start always (re)loads the count, otherwise
  // count down and drop back to IDLE after the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (multdiv_start_execute) begin
      if (multdiv_is_div_execute) begin
        state_d = DIV_BUSY;
        cnt_d   = CNT_W'(DIV_CYCLES - 1);
      end else begin
        state_d = MULT_BUSY;
        cnt_d   = CNT_W'(MULT_CYCLES - 1);
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  assign multdiv_busy = (state_q != IDLE);

  // Operand forwarding selects; HI/LO results win over GPR results, the
  // nearer stage wins over the farther one, and r0 is never forwarded.
  always_comb begin
    forward_one_execute = 3'b000;
    forward_two_execute = 3'b000;

    if (HILO_FWD && use_lo_execute && hi_lo_write_memory)
      forward_one_execute = 3'b100;
    else if (HILO_FWD && use_lo_execute && hi_lo_write_writeback)
      forward_one_execute = 3'b011;
    else if ((rs_execute != 5'd0) && reg_write_memory &&
             (rs_execute == write_reg_memory))
      forward_one_execute = 3'b010;
    else if ((rs_execute != 5'd0) && reg_write_writeback &&
             (rs_execute == write_reg_writeback))
      forward_one_execute = 3'b001;

    if (HILO_FWD && use_hi_execute && hi_lo_write_memory)
      forward_two_execute = 3'b100;
    else if (HILO_FWD && use_hi_execute && hi_lo_write_writeback)
      forward_two_execute = 3'b011;
    else if ((rt_execute != 5'd0) && reg_write_memory &&
             (rt_execute == write_reg_memory))
      forward_two_execute = 3'b010;
    else if ((rt_execute != 5'd0) && reg_write_writeback &&
             (rt_execute == write_reg_writeback))
      forward_two_execute = 3'b001;
  end

  // Stall sources: load-use, branch operands not yet available in decode,
  // HI/LO access while the multiplier/divider is running, and (without
  // HI/LO forwarding) HI/LO access while a HI/LO write is still in flight.
  always_comb begin
    dec_rs_hit_ex  = (write_reg_execute != 5'd0) && (write_reg_execute == rs_decode);
    dec_rt_hit_ex  = (write_reg_execute != 5'd0) && (write_reg_execute == rt_decode);
    dec_rs_hit_mem = (write_reg_memory  != 5'd0) && (write_reg_memory  == rs_decode);
    dec_rt_hit_mem = (write_reg_memory  != 5'd0) && (write_reg_memory  == rt_decode);

    load_use_stall   = mem_to_reg_execute && reg_write_execute &&
                       (dec_rs_hit_ex || dec_rt_hit_ex);
    branch_stall     = branch_decode &&
                       ((reg_write_execute && (dec_rs_hit_ex || dec_rt_hit_ex)) ||
                        (mem_to_reg_memory && (dec_rs_hit_mem || dec_rt_hit_mem)));
    hilo_busy_stall  = hi_lo_access_decode && (multdiv_busy || multdiv_start_execute);
    hilo_write_stall = !HILO_FWD && hi_lo_access_decode &&
                       (hi_lo_write_execute || hi_lo_write_memory || hi_lo_write_writeback);

    stall_fetch   = load_use_stall || branch_stall || hilo_busy_stall || hilo_write_stall;
    stall_decode  = stall_fetch;
    flush_execute = stall_fetch;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, directed
// multi-cycle sequences, then randomized stimulus against a reference model.
module tb_hazard_controller;

  localparam int MC = 4;
  localparam int DC = 32;

`ifdef HAZARD_FORWARD_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
  logic       branch_decode, hi_lo_access_decode;
  logic [4:0] write_reg_execute, write_reg_memory, write_reg_writeback;
  logic       reg_write_execute, mem_to_reg_execute;
  logic       reg_write_memory, mem_to_reg_memory, reg_write_writeback;
  logic       use_lo_execute, use_hi_execute;
  logic       hi_lo_write_execute, hi_lo_write_memory, hi_lo_write_writeback;
  logic       multdiv_start_execute, multdiv_is_div_execute;
  logic [2:0] forward_one_execute, forward_two_execute;
  logic       stall_fetch, stall_decode, flush_execute, multdiv_busy;

  int checks = 0;
  int errors = 0;
  int busy_left = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .rs_decode(rs_decode), .rt_decode(rt_decode),
    .rs_execute(rs_execute), .rt_execute(rt_execute),
    .branch_decode(branch_decode), .hi_lo_access_decode(hi_lo_access_decode),
    .write_reg_execute(write_reg_execute), .reg_write_execute(reg_write_execute),
    .mem_to_reg_execute(mem_to_reg_execute),
    .write_reg_memory(write_reg_memory), .reg_write_memory(reg_write_memory),
    .mem_to_reg_memory(mem_to_reg_memory),
    .write_reg_writeback(write_reg_writeback), .reg_write_writeback(reg_write_writeback),
    .use_lo_execute(use_lo_execute), .use_hi_execute(use_hi_execute),
    .hi_lo_write_execute(hi_lo_write_execute), .hi_lo_write_memory(hi_lo_write_memory),
    .hi_lo_write_writeback(hi_lo_write_writeback),
    .multdiv_start_execute(multdiv_start_execute),
    .multdiv_is_div_execute(multdiv_is_div_execute),
    .forward_one_execute(forward_one_execute), .forward_two_execute(forward_two_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute(flush_execute), .multdiv_busy(multdiv_busy)
  );

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, m2r_e, rw_m, m2r_m, rw_w, br, hla;
    logic       use_lo, use_hi, hlw_e, hlw_m, hlw_w;
    logic [2:0] f1, f2;
    logic       st;
  } tv_t;

  tv_t tq[$];

  task automatic drive_vec(input tv_t v);
    reset = 1'b0;
    rs_decode = v.rs_d; rt_decode = v.rt_d; rs_execute = v.rs_e; rt_execute = v.rt_e;
    write_reg_execute = v.wr_e; write_reg_memory = v.wr_m; write_reg_writeback = v.wr_w;
    reg_write_execute = v.rw_e; mem_to_reg_execute = v.m2r_e;
    reg_write_memory = v.rw_m; mem_to_reg_memory = v.m2r_m; reg_write_writeback = v.rw_w;
    branch_decode = v.br; hi_lo_access_decode = v.hla;
    use_lo_execute = v.use_lo; use_hi_execute = v.use_hi;
    hi_lo_write_execute = v.hlw_e; hi_lo_write_memory = v.hlw_m; hi_lo_write_writeback = v.hlw_w;
    multdiv_start_execute = 1'b0; multdiv_is_div_execute = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] f1, input logic [2:0] f2,
                           input logic st, input logic busy);
    chk({tag, ".fwdA"}, forward_one_execute, f1);
    chk({tag, ".fwdB"}, forward_two_execute, f2);
    chk({tag, ".stall_fetch"}, {2'b0, stall_fetch}, {2'b0, st});
    chk({tag, ".stall_decode"}, {2'b0, stall_decode}, {2'b0, st});
    chk({tag, ".flush"}, {2'b0, flush_execute}, {2'b0, st});
    chk({tag, ".busy"}, {2'b0, multdiv_busy}, {2'b0, busy});
  endtask

  // Reference model of the multiply/divide unit: number of busy cycles left.
  task automatic tick();
    if (reset) busy_left = 0;
    else if (multdiv_start_execute) busy_left = multdiv_is_div_execute ? DC : MC;
    else if (busy_left > 0) busy_left--;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] m_fwd(input logic [4:0] src, input logic use_hl);
    if (HILO && use_hl && hi_lo_write_memory) return 3'd4;
    if (HILO && use_hl && hi_lo_write_writeback) return 3'd3;
    if (src == 5'd0) return 3'd0;
    if (reg_write_memory && write_reg_memory == src) return 3'd2;
    if (reg_write_writeback && write_reg_writeback == src) return 3'd1;
    return 3'd0;
  endfunction

  task automatic model_outputs(output logic [2:0] ef1, output logic [2:0] ef2,
                               output logic est, output logic eb);
    logic [4:0] reads [2];
    bit lu, bs, hb, hw;
    reads[0] = rs_decode;
    reads[1] = rt_decode;
    lu = 0; bs = 0;
    foreach (reads[k]) begin
      if (reads[k] != 5'd0) begin
        if (mem_to_reg_execute && reg_write_execute && write_reg_execute == reads[k]) lu = 1;
        if (branch_decode && reg_write_execute && write_reg_execute == reads[k]) bs = 1;
        if (branch_decode && mem_to_reg_memory && write_reg_memory == reads[k]) bs = 1;
      end
    end
    hb  = hi_lo_access_decode && (busy_left > 0 || multdiv_start_execute);
    hw  = !HILO && hi_lo_access_decode &&
          (hi_lo_write_execute || hi_lo_write_memory || hi_lo_write_writeback);
    ef1 = m_fwd(rs_execute, use_lo_execute);
    ef2 = m_fwd(rt_execute, use_hi_execute);
    est = lu || bs || hb || hw;
    eb  = (busy_left > 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv_t z, v;
    logic [2:0] ef1, ef2;
    logic est, eb;
    z = '0;

    // Reset with quiescent inputs
    drive_vec(z);
    reset = 1'b1;
    @(posedge clk); #1;
    #4; check_all("reset", 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Combinational vector table (sequencer idle)
    v = z; v.rs_e = 5; v.wr_m = 5; v.rw_m = 1; v.wr_w = 5; v.rw_w = 1; v.f1 = 3'b010; tq.push_back(v);
    v = z; v.rs_e = 5; v.wr_m = 5; v.wr_w = 5; v.rw_w = 1; v.f1 = 3'b001; tq.push_back(v);
    v = z; v.rw_m = 1; v.rw_w = 1; tq.push_back(v);
    v = z; v.rt_e = 7; v.wr_m = 7; v.rw_m = 1; v.f2 = 3'b010; tq.push_back(v);
    v = z; v.rt_e = 7; v.wr_m = 6; v.rw_m = 1; v.wr_w = 7; v.rw_w = 1; v.f2 = 3'b001; tq.push_back(v);
    v = z; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8; v.st = 1; tq.push_back(v);
    v = z; v.m2r_e = 1; v.rw_e = 1; tq.push_back(v);
    v = z; v.m2r_e = 1; v.wr_e = 8; v.rs_d = 8; tq.push_back(v);
    v = z; v.br = 1; v.rw_e = 1; v.wr_e = 3; v.rs_d = 3; v.st = 1; tq.push_back(v);
    v = z; v.br = 1; v.rw_e = 1; tq.push_back(v);
    v = z; v.rw_e = 1; v.wr_e = 3; v.rs_d = 3; tq.push_back(v);
    v = z; v.br = 1; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 4; v.rt_d = 4; v.st = 1; tq.push_back(v);
    v = z; v.use_hi = 1; v.hlw_m = 1; v.f2 = HILO ? 3'b100 : 3'b000; tq.push_back(v);
    v = z; v.use_lo = 1; v.hlw_w = 1; v.rs_e = 2; v.wr_m = 2; v.rw_m = 1;
    v.f1 = HILO ? 3'b011 : 3'b010; tq.push_back(v);
    v = z; v.use_lo = 1; v.hlw_m = 1; v.hlw_w = 1; v.f1 = HILO ? 3'b100 : 3'b000; tq.push_back(v);
    v = z; v.hla = 1; v.hlw_e = 1; v.st = !HILO; tq.push_back(v);
    v = z; v.hla = 1; v.hlw_w = 1; v.st = !HILO; tq.push_back(v);
    v = z; v.hla = 1; tq.push_back(v);

    foreach (tq[i]) begin
      drive_vec(tq[i]);
      #4; check_all($sformatf("vec%0d", i), tq[i].f1, tq[i].f2, tq[i].st, 1'b0);
      tick();
    end

    // Load-use: stall, then bubble, then forward from writeback
    v = z; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8; drive_vec(v);
    #4; check_all("lu.stall", 3'd0, 3'd0, 1'b1, 1'b0); tick();
    v = z; v.rt_d = 8; v.wr_m = 8; v.rw_m = 1; v.m2r_m = 1; drive_vec(v);
    #4; check_all("lu.bubble", 3'd0, 3'd0, 1'b0, 1'b0); tick();
    v = z; v.rt_e = 8; v.wr_w = 8; v.rw_w = 1; drive_vec(v);
    #4; check_all("lu.fwd", 3'd0, 3'b001, 1'b0, 1'b0); tick();

    // DIV with an MFLO held in decode
    v = z; v.hla = 1; drive_vec(v);
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1;
    #4; check_all("div.start", 3'd0, 3'd0, 1'b1, 1'b0); tick();
    for (int k = 1; k <= DC; k++) begin
      drive_vec(v);
      #4; check_all($sformatf("div.busy%0d", k), 3'd0, 3'd0, 1'b1, 1'b1); tick();
    end
    drive_vec(v);
    #4; check_all("div.release", 3'd0, 3'd0, 1'b0, 1'b0); tick();

    // MULT aborted by reset
    v = z; v.hla = 1; drive_vec(v);
    multdiv_start_execute = 1'b1;
    #4; check_all("mul.start", 3'd0, 3'd0, 1'b1, 1'b0); tick();
    drive_vec(v);
    #4; check_all("mul.busy", 3'd0, 3'd0, 1'b1, 1'b1); tick();
    drive_vec(z); reset = 1'b1;
    #4; check_all("mul.reset", 3'd0, 3'd0, 1'b0, 1'b1); tick();
    drive_vec(v);
    #4; check_all("mul.after", 3'd0, 3'd0, 1'b0, 1'b0); tick();

    // HI/LO producer followed by a HI reader
    if (HILO) begin
      v = z; v.hla = 1; v.hlw_e = 1; drive_vec(v);
      #4; check_all("hl.dec", 3'd0, 3'd0, 1'b0, 1'b0); tick();
      v = z; v.use_hi = 1; v.hlw_m = 1; drive_vec(v);
      #4; check_all("hl.fwd", 3'd0, 3'b100, 1'b0, 1'b0); tick();
    end else begin
      v = z; v.hla = 1; v.hlw_e = 1; drive_vec(v);
      #4; check_all("hl.dec", 3'd0, 3'd0, 1'b1, 1'b0); tick();
      v = z; v.hla = 1; v.hlw_m = 1; drive_vec(v);
      #4; check_all("hl.mem", 3'd0, 3'd0, 1'b1, 1'b0); tick();
      v = z; v.hla = 1; v.hlw_w = 1; drive_vec(v);
      #4; check_all("hl.wb", 3'd0, 3'd0, 1'b1, 1'b0); tick();
      v = z; v.hla = 1; drive_vec(v);
      #4; check_all("hl.free", 3'd0, 3'd0, 1'b0, 1'b0); tick();
      v = z; v.use_hi = 1; drive_vec(v);
      #4; check_all("hl.read", 3'd0, 3'd0, 1'b0, 1'b0); tick();
    end

    // Randomized stimulus against the reference model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        drive_vec(z);
        reset = 1'b1;
      end else begin
        v = z;
        v.rs_d = 5'($urandom_range(0, 3)); v.rt_d = 5'($urandom_range(0, 3));
        v.rs_e = 5'($urandom_range(0, 3)); v.rt_e = 5'($urandom_range(0, 3));
        v.wr_e = 5'($urandom_range(0, 3)); v.wr_m = 5'($urandom_range(0, 3));
        v.wr_w = 5'($urandom_range(0, 3));
        v.rw_e = 1'($urandom); v.m2r_e = 1'($urandom); v.rw_m = 1'($urandom);
        v.m2r_m = 1'($urandom); v.rw_w = 1'($urandom); v.br = 1'($urandom);
        v.hla = 1'($urandom); v.use_lo = 1'($urandom); v.use_hi = 1'($urandom);
        v.hlw_e = ($urandom_range(0, 3) == 0); v.hlw_m = ($urandom_range(0, 3) == 0);
        v.hlw_w = ($urandom_range(0, 3) == 0);
        drive_vec(v);
        multdiv_start_execute  = ($urandom_range(0, 9) == 0);
        multdiv_is_div_execute = 1'($urandom);
      end
      #4;
      model_outputs(ef1, ef2, est, eb);
      check_all($sformatf("rnd%0d", i), ef1, ef2, est, eb);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
